// File: rtl/ddram_rom_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddram_rom_port_pkg
//  Description : Shared types and constants for the ROM-path DDRAM responder:
//                FSM state encoding, line/lane geometry, byte-enable helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ddram_rom_port_pkg;

   // Top-level FSM states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WR_ISSUE = 2'd1,
      ST_RD_ISSUE = 2'd2,
      ST_RD_WAIT  = 2'd3
   } state_t;

   localparam int          c_AW       = 25;          // ROM byte address width
   localparam int          c_LINE_W   = c_AW - 3;    // 64-bit line index width
   localparam int          c_LANE_W   = 16;          // halfword lane width
   localparam int          c_BE_W     = 8;           // byte enables per line
   localparam logic [7:0]  c_BURSTCNT = 8'd1;        // single-beat transfers

   // Two byte-enable bits belonging to halfword lane k
   function automatic logic [c_BE_W-1:0] lane_be(input logic [1:0] lane);
      return 8'b0000_0011 << {lane, 1'b0};
   endfunction

endpackage : ddram_rom_port_pkg
`default_nettype wire

// File: rtl/ddram_rom_port_hw_pack64.sv
`default_nettype none
// ============================================================================
//  Module      : hw_pack64
//  Description : One-line write buffer. Packs 16-bit halfwords into a 64-bit
//                line, accumulates byte enables and reports whether an
//                incoming write targets the buffered line.
//  Revision    : 1.0 - initial release
// ============================================================================
module hw_pack64
   import ddram_rom_port_pkg::*;
#(
   parameter int LINE_W = c_LINE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_ins,       // store halfword into its lane
   input  logic [1:0]        i_lane,
   input  logic [15:0]       i_hw,
   input  logic [LINE_W-1:0] i_line,
   input  logic              i_clr,       // empty the buffer
   output logic              o_valid,
   output logic [LINE_W-1:0] o_line,
   output logic [63:0]       o_data,
   output logic [7:0]        o_be,
   output logic              o_same_line, // buffer valid and i_line matches
   output logic [63:0]       o_ins_data,  // buffer contents with i_hw merged
   output logic [7:0]        o_ins_be     // byte enables with i_lane merged
);

   logic              r_valid;
   logic [LINE_W-1:0] r_line;
   logic [63:0]       r_data;
   logic [7:0]        r_be;

   // Merge the incoming halfword over the current contents (overwrite allowed)
   always_comb begin
      o_ins_data = r_data;
      o_ins_data[c_LANE_W*i_lane +: c_LANE_W] = i_hw;
      o_ins_be   = r_be | lane_be(i_lane);
   end

   // Buffer storage; clearing zeroes data so partial lines carry zero fill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_line  <= '0;
         r_data  <= '0;
         r_be    <= '0;
      end else if (i_clr) begin
         r_valid <= 1'b0;
         r_line  <= '0;
         r_data  <= '0;
         r_be    <= '0;
      end else if (i_ins) begin
         r_valid <= 1'b1;
         r_line  <= i_line;
         r_data  <= o_ins_data;
         r_be    <= o_ins_be;
      end
   end

   assign o_valid     = r_valid;
   assign o_line      = r_line;
   assign o_data      = r_data;
   assign o_be        = r_be;
   assign o_same_line = r_valid && (r_line == i_line);

endmodule : hw_pack64
`default_nettype wire

// File: rtl/ddram_rom_port.sv
`default_nettype none
// ============================================================================
//  Module      : ddram_rom_port
//  Description : Toggle-handshake responder between the ROM loader/core and
//                the DDRAM port. Packs halfword writes into 64-bit lines and
//                serves line reads through a one-entry cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddram_rom_port
   import ddram_rom_port_pkg::*;
#(
   parameter logic [28:0] BASE_ADDR = 29'h6000000,
   parameter int          AW        = c_AW
) (
   input  logic          RAMCLK,
   input  logic          RESET_N,
   input  logic [AW-1:0] wraddr,
   input  logic [15:0]   din,
   input  logic          we_req,
   output logic          we_ack,
   input  logic          flush,
   input  logic [AW-1:0] rdaddr,
   input  logic          rd_req,
   output logic          rd_ack,
   output logic [63:0]   dout,
   output logic          DDRAM_CLK,
   input  logic          DDRAM_BUSY,
   output logic [7:0]    DDRAM_BURSTCNT,
   output logic [28:0]   DDRAM_ADDR,
   output logic [63:0]   DDRAM_DIN,
   output logic [7:0]    DDRAM_BE,
   output logic          DDRAM_WE,
   output logic          DDRAM_RD,
   input  logic [63:0]   DDRAM_DOUT,
   input  logic          DDRAM_DOUT_READY
);

   localparam int LINE_W = AW - 3;

   state_t            r_state;
   logic              r_cache_valid;
   logic [LINE_W-1:0] r_cache_tag;
   logic [63:0]       r_cache_data;

   logic              w_wr_pend;
   logic              w_rd_pend;
   logic [LINE_W-1:0] w_wr_line;
   logic [1:0]        w_wr_lane;
   logic [LINE_W-1:0] w_rd_line;
   logic              w_cache_hit;
   logic              w_buf_ins;
   logic              w_buf_clr;
   logic              w_buf_valid;
   logic [LINE_W-1:0] w_buf_line;
   logic [63:0]       w_buf_data;
   logic [7:0]        w_buf_be;
   logic              w_buf_same;
   logic [63:0]       w_ins_data;
   logic [7:0]        w_ins_be;
   logic              w_unused;

   assign w_wr_pend   = (we_req != we_ack);
   assign w_rd_pend   = (rd_req != rd_ack);
   assign w_wr_line   = wraddr[AW-1:3];
   assign w_wr_lane   = wraddr[2:1];
   assign w_rd_line   = rdaddr[AW-1:3];
   assign w_cache_hit = r_cache_valid && (r_cache_tag == w_rd_line);
   assign w_unused    = ^{wraddr[0], rdaddr[2:0]};

   assign DDRAM_CLK      = RAMCLK;
   assign DDRAM_BURSTCNT = c_BURSTCNT;

   // Write buffer controls: accept into buffer from IDLE, clear on DDRAM accept
   always_comb begin
      w_buf_ins = 1'b0;
      w_buf_clr = 1'b0;
      if (r_state == ST_IDLE && w_wr_pend && (!w_buf_valid || w_buf_same))
         w_buf_ins = 1'b1;
      if (r_state == ST_WR_ISSUE && !DDRAM_BUSY)
         w_buf_clr = 1'b1;
   end

   hw_pack64 #(
      .LINE_W (LINE_W)
   ) u_pack (
      .clk         (RAMCLK),
      .rst_n       (RESET_N),
      .i_ins       (w_buf_ins),
      .i_lane      (w_wr_lane),
      .i_hw        (din),
      .i_line      (w_wr_line),
      .i_clr       (w_buf_clr),
      .o_valid     (w_buf_valid),
      .o_line      (w_buf_line),
      .o_data      (w_buf_data),
      .o_be        (w_buf_be),
      .o_same_line (w_buf_same),
      .o_ins_data  (w_ins_data),
      .o_ins_be    (w_ins_be)
   );

   // Control FSM with registered handshake and DDRAM command outputs
   always_ff @(posedge RAMCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state       <= ST_IDLE;
         r_cache_valid <= 1'b0;
         r_cache_tag   <= '0;
         r_cache_data  <= '0;
         we_ack        <= 1'b0;
         rd_ack        <= 1'b0;
         dout          <= '0;
         DDRAM_WE      <= 1'b0;
         DDRAM_RD      <= 1'b0;
         DDRAM_ADDR    <= '0;
         DDRAM_DIN     <= '0;
         DDRAM_BE      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_wr_pend) begin
                  if (!w_buf_valid || w_buf_same) begin
                     we_ack <= ~we_ack;
                     // Top lane completes the line: ship it straight away
                     if (w_wr_lane == 2'd3) begin
                        r_state    <= ST_WR_ISSUE;
                        DDRAM_WE   <= 1'b1;
                        DDRAM_ADDR <= BASE_ADDR + 29'(w_wr_line);
                        DDRAM_DIN  <= w_ins_data;
                        DDRAM_BE   <= w_ins_be;
                     end
                  end else begin
                     // Line change: evict the old line, new write waits
                     r_state    <= ST_WR_ISSUE;
                     DDRAM_WE   <= 1'b1;
                     DDRAM_ADDR <= BASE_ADDR + 29'(w_buf_line);
                     DDRAM_DIN  <= w_buf_data;
                     DDRAM_BE   <= w_buf_be;
                  end
               end else if (flush && w_buf_valid) begin
                  r_state    <= ST_WR_ISSUE;
                  DDRAM_WE   <= 1'b1;
                  DDRAM_ADDR <= BASE_ADDR + 29'(w_buf_line);
                  DDRAM_DIN  <= w_buf_data;
                  DDRAM_BE   <= w_buf_be;
               end else if (w_rd_pend) begin
                  if (w_cache_hit) begin
                     dout   <= r_cache_data;
                     rd_ack <= ~rd_ack;
                  end else begin
                     r_state    <= ST_RD_ISSUE;
                     DDRAM_RD   <= 1'b1;
                     DDRAM_ADDR <= BASE_ADDR + 29'(w_rd_line);
                  end
               end
            end
            ST_WR_ISSUE: begin
               if (!DDRAM_BUSY) begin
                  DDRAM_WE <= 1'b0;
                  // Written line may be the cached one; drop the stale copy
                  if (r_cache_tag == w_buf_line)
                     r_cache_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_RD_ISSUE: begin
               if (!DDRAM_BUSY) begin
                  DDRAM_RD <= 1'b0;
                  r_state  <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               if (DDRAM_DOUT_READY) begin
                  dout          <= DDRAM_DOUT;
                  r_cache_data  <= DDRAM_DOUT;
                  r_cache_tag   <= w_rd_line;
                  r_cache_valid <= 1'b1;
                  rd_ack        <= ~rd_ack;
                  r_state       <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule : ddram_rom_port
`default_nettype wire

// File: tb/tb_ddram_rom_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddram_rom_port
//  Description : Directed testbench for ddram_rom_port with queue-based
//                expectations checked by an independent output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddram_rom_port;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [24:0]   wraddr;
   logic [15:0]   din;
   logic          we_req;
   logic          we_ack;
   logic          flush;
   logic [24:0]   rdaddr;
   logic          rd_req;
   logic          rd_ack;
   logic [63:0]   dout;
   logic          ddram_clk;
   logic          busy;
   logic [7:0]    burstcnt;
   logic [28:0]   ddr_addr;
   logic [63:0]   ddr_din;
   logic [7:0]    ddr_be;
   logic          ddr_we;
   logic          ddr_rd;
   logic [63:0]   ddr_dout;
   logic          ddr_ready;

   always #5 clk = ~clk;

   ddram_rom_port dut (
      .RAMCLK           (clk),
      .RESET_N          (rst_n),
      .wraddr           (wraddr),
      .din              (din),
      .we_req           (we_req),
      .we_ack           (we_ack),
      .flush            (flush),
      .rdaddr           (rdaddr),
      .rd_req           (rd_req),
      .rd_ack           (rd_ack),
      .dout             (dout),
      .DDRAM_CLK        (ddram_clk),
      .DDRAM_BUSY       (busy),
      .DDRAM_BURSTCNT   (burstcnt),
      .DDRAM_ADDR       (ddr_addr),
      .DDRAM_DIN        (ddr_din),
      .DDRAM_BE         (ddr_be),
      .DDRAM_WE         (ddr_we),
      .DDRAM_RD         (ddr_rd),
      .DDRAM_DOUT       (ddr_dout),
      .DDRAM_DOUT_READY (ddr_ready)
   );

   typedef struct {
      logic [28:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
      int          acks;   // cumulative we_ack toggles seen when WE rises
      int          hold;   // cycles WE is high including the accept cycle
   } wr_exp_t;

   wr_exp_t     exp_wr[$];
   logic [28:0] exp_rd_cmd[$];
   logic [63:0] exp_resp[$];

   int n_pass  = 0;
   int n_total = 0;

   logic        resp_en = 1'b0;
   logic [63:0] rd_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_evt(input string name);
      n_total++;
      $display("FAIL %s: got event expected none", name);
   endtask

   // Monitor: compares every DDRAM command and read acknowledge to the queues
   initial begin : p_monitor
      int          ack_toggles = 0;
      logic        prev_we_ack = 1'b0;
      logic        prev_rd_ack = 1'b0;
      int          we_hi = 0;
      int          snap_acks = 0;
      logic        stable = 1'b1;
      logic [28:0] cap_addr = '0;
      logic [63:0] cap_data = '0;
      logic [7:0]  cap_be = '0;
      wr_exp_t     e;
      logic [28:0] ea;
      logic [63:0] ed;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_we_ack = 1'b0;
            prev_rd_ack = 1'b0;
            we_hi       = 0;
         end else begin
            if (we_ack != prev_we_ack) begin
               ack_toggles++;
               prev_we_ack = we_ack;
            end
            if (ddr_we) begin
               if (we_hi == 0) begin
                  cap_addr  = ddr_addr;
                  cap_data  = ddr_din;
                  cap_be    = ddr_be;
                  snap_acks = ack_toggles;
                  stable    = 1'b1;
               end else if (ddr_addr != cap_addr || ddr_din != cap_data || ddr_be != cap_be) begin
                  stable = 1'b0;
               end
               we_hi++;
               if (!busy) begin
                  if (exp_wr.size() == 0) fail_evt("unexpected_ddram_we");
                  else begin
                     e = exp_wr.pop_front();
                     chk("we_addr", 64'(ddr_addr), 64'(e.addr));
                     chk("we_din", ddr_din, e.data);
                     chk("we_be", 64'(ddr_be), 64'(e.be));
                     chk("we_acks_before", 64'(snap_acks), 64'(e.acks));
                     chk("we_hold_cycles", 64'(we_hi), 64'(e.hold));
                     chk("we_stable", 64'(stable), 64'd1);
                  end
                  we_hi = 0;
               end
            end
            if (ddr_rd && !busy) begin
               if (exp_rd_cmd.size() == 0) fail_evt("unexpected_ddram_rd");
               else begin
                  ea = exp_rd_cmd.pop_front();
                  chk("rd_addr", 64'(ddr_addr), 64'(ea));
               end
            end
            if (rd_ack != prev_rd_ack) begin
               prev_rd_ack = rd_ack;
               if (exp_resp.size() == 0) fail_evt("unexpected_rd_ack");
               else begin
                  ed = exp_resp.pop_front();
                  chk("rd_dout", dout, ed);
               end
            end
         end
      end
   end

   // DDRAM read-data model: returns rd_data three cycles after a read accept
   initial begin : p_responder
      ddr_ready = 1'b0;
      ddr_dout  = '0;
      forever begin
         @(negedge clk);
         if (rst_n && ddr_rd && !busy && resp_en) begin
            repeat (2) @(posedge clk);
            #1;
            ddr_dout  = rd_data;
            ddr_ready = 1'b1;
            @(posedge clk);
            #1;
            ddr_ready = 1'b0;
         end
      end
   end

   task automatic do_write(input logic [24:0] a, input logic [15:0] d);
      wraddr = a;
      din    = d;
      we_req = ~we_req;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (we_ack == we_req) return;
      end
      fail_evt("we_ack_timeout");
   endtask

   task automatic do_read(input logic [24:0] a, output int lat);
      rdaddr = a;
      rd_req = ~rd_req;
      lat    = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (rd_ack == rd_req) return;
      end
      fail_evt("rd_ack_timeout");
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300; i++) begin
         if (exp_wr.size() == 0 && exp_rd_cmd.size() == 0 && exp_resp.size() == 0) break;
         @(posedge clk);
         #1;
      end
      chk("drain", 64'(exp_wr.size() + exp_rd_cmd.size() + exp_resp.size()), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_we_ack"}, 64'(we_ack), 64'd0);
      chk({tag, "_rd_ack"}, 64'(rd_ack), 64'd0);
      chk({tag, "_dout"}, dout, 64'd0);
      chk({tag, "_ddram_we"}, 64'(ddr_we), 64'd0);
      chk({tag, "_ddram_rd"}, 64'(ddr_rd), 64'd0);
      chk({tag, "_ddram_be"}, 64'(ddr_be), 64'd0);
      chk({tag, "_ddram_addr"}, 64'(ddr_addr), 64'd0);
      chk({tag, "_ddram_din"}, ddr_din, 64'd0);
   endtask

   initial begin : p_stim
      int lat;
      rst_n  = 1'b0;
      wraddr = '0;
      din    = '0;
      we_req = 1'b0;
      flush  = 1'b0;
      rdaddr = '0;
      rd_req = 1'b0;
      busy   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      chk("burstcnt", 64'(burstcnt), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Full line: four lanes then a single write with all byte enables
      exp_wr.push_back('{29'h6000000, 64'h4444_3333_2222_1111, 8'hFF, 4, 1});
      do_write(25'h0, 16'h1111);
      do_write(25'h2, 16'h2222);
      do_write(25'h4, 16'h3333);
      do_write(25'h6, 16'h4444);
      wait_drain();

      // Partial line evicted by a line change, then explicit flush
      exp_wr.push_back('{29'h6000002, 64'h0000_0000_0000_AAAA, 8'h03, 5, 1});
      exp_wr.push_back('{29'h6000004, 64'h0000_0000_0000_BBBB, 8'h03, 6, 1});
      do_write(25'h10, 16'hAAAA);
      do_write(25'h20, 16'hBBBB);
      flush = 1'b1;
      wait_drain();
      flush = 1'b0;

      // Flush stalled by BUSY for five cycles
      exp_wr.push_back('{29'h6000006, 64'h0000_0000_0000_CCCC, 8'h03, 7, 6});
      do_write(25'h30, 16'hCCCC);
      busy  = 1'b1;
      flush = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (ddr_we) break;
      end
      repeat (5) @(posedge clk);
      #1;
      busy = 1'b0;
      wait_drain();
      flush = 1'b0;

      // Read miss, then hit on the same line at a different byte offset
      resp_en = 1'b1;
      rd_data = 64'h0123_4567_89AB_CDEF;
      exp_rd_cmd.push_back(29'h6000008);
      exp_resp.push_back(64'h0123_4567_89AB_CDEF);
      do_read(25'h40, lat);
      exp_resp.push_back(64'h0123_4567_89AB_CDEF);
      do_read(25'h47, lat);
      chk("hit_latency", 64'(lat), 64'd1);
      wait_drain();

      // Writing the cached line invalidates it; next read goes to DDRAM
      exp_wr.push_back('{29'h6000008, 64'h0000_0000_0000_5555, 8'h03, 8, 1});
      do_write(25'h40, 16'h5555);
      flush = 1'b1;
      wait_drain();
      flush = 1'b0;
      rd_data = 64'hFEDC_BA98_7654_3210;
      exp_rd_cmd.push_back(29'h6000008);
      exp_resp.push_back(64'hFEDC_BA98_7654_3210);
      do_read(25'h40, lat);
      wait_drain();

      // Asynchronous reset while waiting on read data
      resp_en = 1'b0;
      exp_rd_cmd.push_back(29'h6000010);
      rdaddr = 25'h80;
      rd_req = ~rd_req;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (exp_rd_cmd.size() == 0) break;
      end
      chk("rd_issue_seen", 64'(exp_rd_cmd.size()), 64'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n  = 1'b0;
      rd_req = 1'b0;
      we_req = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      @(posedge clk);
      #1;
      ddr_dout  = 64'hDEAD_BEEF_DEAD_BEEF;
      ddr_ready = 1'b1;
      @(posedge clk);
      #1;
      ddr_ready = 1'b0;
      rst_n     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      ddr_ready = 1'b1;
      @(posedge clk);
      #1;
      ddr_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("post_reset_rd_ack", 64'(rd_ack), 64'd0);
      chk("post_reset_dout", dout, 64'd0);
      chk("post_reset_ddram_rd", 64'(ddr_rd), 64'd0);
      chk("queues_empty", 64'(exp_wr.size() + exp_rd_cmd.size() + exp_resp.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_ddram_rom_port
`default_nettype wire
